// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with programmable thresholds, fill level, flush and sticky error flags
module sync_fifo_ctl #(
  parameter int    DSIZE       = 8,
  parameter int    ASIZE       = 4,
  parameter string FALLTHROUGH = "TRUE"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic [ASIZE:0]   level,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic [ASIZE:0]   aempty_thresh,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL = {1'b1, {ASIZE{1'b0}}};
  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] waddr, raddr;
  logic             we, re;
  assign wfull   = level == FULL;
  assign rempty  = level == '0;
  assign awfull  = level >= afull_thresh;
  assign arempty = level <= aempty_thresh;
  assign we      = winc && !wfull && !flush;
  assign re      = rinc && !rempty && !flush;
  // storage array; never reset, flush leaves contents in place
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // pointers and fill level; flush empties without touching memory
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      waddr <= '0;
      raddr <= '0;
      level <= '0;
    end else if (flush) begin
      waddr <= '0;
      raddr <= '0;
      level <= '0;
    end else begin
      if (we) waddr <= waddr + 1'b1;
      if (re) raddr <= raddr + 1'b1;
      if (we != re) level <= we ? level + 1'b1 : level - 1'b1;
    end
  // sticky errors; a new error in the clearing cycle wins over err_clr
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (winc && wfull && !flush) || (overflow && !err_clr);
      underflow <= (rinc && rempty && !flush) || (underflow && !err_clr);
    end
  if (FALLTHROUGH == "TRUE") begin : g_ft
    assign rdata = mem[raddr];
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q;
    // registered read port, loads only on an accepted pop
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata_q <= '0;
      else if (re) rdata_q <= mem[raddr];
    assign rdata = rdata_q;
  end
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb_sync_fifo_ctl: checks both read modes of sync_fifo_ctl against a queue model plus directed pins
module tb_sync_fifo_ctl;
  logic       clk = 0, rst_n = 0, flush = 0, winc = 0, rinc = 0, err_clr = 0;
  logic [7:0] wdata = 0;
  logic [4:0] afull_thresh = 0, aempty_thresh = 0;
  logic       wfull_t, awfull_t, rempty_t, arempty_t, ovf_t, unf_t;
  logic       wfull_f, awfull_f, rempty_f, arempty_f, ovf_f, unf_f;
  logic [7:0] rdata_t, rdata_f;
  logic [4:0] level_t, level_f;
  int n_chk = 0, n_fail = 0;
  logic [7:0] q[$];
  logic       ovf_m = 0, unf_m = 0;
  logic [7:0] rdf_m = 0;
  bit         m_full, m_empty;

  sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("TRUE")) u_t (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(wfull_t), .awfull(awfull_t), .rinc(rinc), .rdata(rdata_t),
    .rempty(rempty_t), .arempty(arempty_t), .level(level_t),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .overflow(ovf_t), .underflow(unf_t), .err_clr(err_clr));

  sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("FALSE")) u_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(wfull_f), .awfull(awfull_f), .rinc(rinc), .rdata(rdata_f),
    .rempty(rempty_f), .arempty(arempty_f), .level(level_f),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .overflow(ovf_f), .underflow(unf_f), .err_clr(err_clr));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f, input logic e);
    winc = w; wdata = d; rinc = r; flush = f; err_clr = e;
    @(posedge clk);
    #1;
  endtask

  // reference model: FIFO contents as a queue, flags from the occupancy count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      ovf_m <= 0;
      unf_m <= 0;
      rdf_m <= 0;
    end else begin
      m_full  = q.size() == 16;
      m_empty = q.size() == 0;
      ovf_m <= (winc && m_full && !flush) || (ovf_m && !err_clr);
      unf_m <= (rinc && m_empty && !flush) || (unf_m && !err_clr);
      if (flush) q.delete();
      else begin
        if (rinc && !m_empty) begin
          rdf_m <= q[0];
          void'(q.pop_front());
        end
        if (winc && !m_full) q.push_back(wdata);
      end
    end
  end

  // every cycle out of reset, both instances must match the model
  always @(negedge clk) if (rst_n) begin
    chk("level_t", level_t, q.size());
    chk("level_f", level_f, q.size());
    chk("wfull_t", wfull_t, q.size() == 16);
    chk("wfull_f", wfull_f, q.size() == 16);
    chk("rempty_t", rempty_t, q.size() == 0);
    chk("rempty_f", rempty_f, q.size() == 0);
    chk("awfull_t", awfull_t, q.size() >= int'(afull_thresh));
    chk("awfull_f", awfull_f, q.size() >= int'(afull_thresh));
    chk("arempty_t", arempty_t, q.size() <= int'(aempty_thresh));
    chk("arempty_f", arempty_f, q.size() <= int'(aempty_thresh));
    chk("overflow_t", ovf_t, ovf_m);
    chk("overflow_f", ovf_f, ovf_m);
    chk("underflow_t", unf_t, unf_m);
    chk("underflow_f", unf_f, unf_m);
    chk("rdata_f", rdata_f, rdf_m);
    if (q.size() != 0) chk("rdata_t", rdata_t, q[0]);
  end

  initial begin
    #1;
    chk("rst_level", level_t, 0);
    chk("rst_rempty", rempty_t, 1);
    chk("rst_wfull", wfull_t, 0);
    chk("rst_arempty", arempty_t, 1);
    chk("rst_awfull_thr0", awfull_t, 1);
    chk("rst_ovf", ovf_t, 0);
    chk("rst_unf", unf_t, 0);
    chk("rst_rdata_f", rdata_f, 0);
    afull_thresh = 12;
    #1;
    chk("rst_awfull_thr12", awfull_t, 0);
    afull_thresh = 16;
    #10 rst_n = 1;
    cyc(1, 8'hA5, 0, 0, 0);
    chk("lat_rdata_t", rdata_t, 8'hA5);
    chk("lat_rempty", rempty_t, 0);
    chk("lat_rdata_f_before", rdata_f, 0);
    cyc(0, 0, 1, 0, 0);
    chk("lat_rdata_f_after", rdata_f, 8'hA5);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("full_level", level_t, 16);
    chk("full_wfull", wfull_t, 1);
    chk("full_ovf_pre", ovf_t, 0);
    cyc(1, 8'hFF, 0, 0, 0);
    chk("full_ovf", ovf_t, 1);
    chk("full_level_hold", level_f, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_rdata_t", rdata_t, i);
      cyc(0, 0, 1, 0, 0);
      chk("drain_rdata_f", rdata_f, i);
    end
    chk("drain_rempty", rempty_t, 1);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_cleared", ovf_t, 0);
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'h40 + i), 1, 0, 0);
    chk("rw8_level", level_t, 8);
    chk("rw8_head", rdata_t, 8'h4C);
    chk("rw8_last_pop", rdata_f, 8'h4B);
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0);
    chk("rw16_wfull", wfull_t, 1);
    cyc(1, 8'h99, 1, 0, 0);
    chk("rw16_level", level_t, 15);
    chk("rw16_ovf", ovf_t, 1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8'h55, 1, 0, 0);
    chk("rw0_level", level_t, 1);
    chk("rw0_unf", unf_t, 1);
    chk("rw0_rdata_t", rdata_t, 8'h55);
    cyc(0, 0, 0, 1, 1);
    chk("flush_clr_level", level_t, 0);
    chk("flush_clr_unf", unf_t, 0);
    afull_thresh = 12;
    aempty_thresh = 3;
    for (int k = 0; k <= 16; k++) begin
      chk("thr_arempty", arempty_t, k <= 3);
      chk("thr_awfull", awfull_t, k >= 12);
      if (k < 16) cyc(1, 8'(k), 0, 0, 0);
    end
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
    chk("fl_level9", level_t, 9);
    cyc(1, 8'h77, 0, 1, 0);
    chk("fl_level", level_t, 0);
    chk("fl_ovf", ovf_t, 0);
    cyc(1, 8'h3C, 0, 0, 0);
    chk("fl_rdata_t", rdata_t, 8'h3C);
    cyc(0, 0, 1, 0, 0);
    chk("fl_rdata_f", rdata_f, 8'h3C);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_mid_level5", level_t, 5);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_level_t", level_t, 0);
    chk("rst_mid_level_f", level_f, 0);
    chk("rst_mid_rempty", rempty_t, 1);
    chk("rst_mid_rdata_f", rdata_f, 0);
    @(negedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 1, 0, 0);
    chk("sticky_set", unf_t, 1);
    cyc(0, 0, 1, 0, 1);
    chk("sticky_set_wins", unf_t, 1);
    cyc(0, 0, 0, 0, 1);
    chk("sticky_clr", unf_t, 0);
    for (int ph = 0; ph < 10; ph++) begin
      int pw;
      afull_thresh  = 5'($urandom_range(0, 16));
      aempty_thresh = 5'($urandom_range(0, 16));
      pw = (ph % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < 100 - pw + 10,
            $urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0);
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Single-clock, parametrised FIFO for the hasher datapath. It generalises the two-clock FIFO with several additions: run-time programmable almost-full/almost-empty thresholds, an exported fill level, synchronous flush, and sticky overflow/underflow error flags with clear. It sits between the I2C byte receiver and the FNV hash core, where both run on the same clock and no pointer synchronisers are needed.

## Interface
Parameters:
- DSIZE, 8, data word width
- ASIZE, 4, address width; DEPTH = 2^ASIZE words
- FALLTHROUGH, "TRUE", "TRUE" = first-word fall-through; "FALSE" = registered read, 1-cycle latency

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous empty request
- winc  in  1  write request
- wdata  in  DSIZE  write data
- wfull  out  1  level == DEPTH
- awfull  out  1  level >= afull_thresh
- rinc  in  1  read request (pop)
- rdata  out  DSIZE  read data
- rempty  out  1  level == 0
- arempty  out  1  level <= aempty_thresh
- level  out  ASIZE+1  current word count, 0..DEPTH
- afull_thresh  in  ASIZE+1  almost-full threshold, static while in use
- aempty_thresh  in  ASIZE+1  almost-empty threshold, static while in use
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  clears overflow/underflow

## Operation
- Storage is a DEPTH x DSIZE register array. Write pointer waddr and read pointer raddr are ASIZE bits and wrap modulo DEPTH. The level register is ASIZE+1 bits.
- Write is accepted when winc && !wfull && !flush. mem[waddr] <= wdata and waddr increments.
- Read is accepted when rinc && !rempty && !flush. raddr increments.
- Acceptance uses the flag values present before the edge.
  - At full, winc && rinc: the read is accepted, the write is dropped and overflow is set.
  - At empty, winc && rinc: the write is accepted, the read is dropped and underflow is set.
- Level update:
  - +1 on an accepted write only
  - -1 on an accepted read only
  - unchanged when both or neither are accepted
  - never leaves the range 0..DEPTH
- wfull, rempty, awfull and arempty are combinational decodes of level and the threshold inputs.
- FALLTHROUGH="TRUE": rdata = mem[raddr] combinationally. It is valid whenever rempty=0 and is undefined-but-stable when empty.
- FALLTHROUGH="FALSE": rdata is a register loaded with mem[raddr] on an accepted read. It holds otherwise, including across flush.
- flush has priority over winc and rinc. At the edge it sets waddr=raddr=0 and level=0. Memory contents are not cleared. Sticky flags are unaffected by flush. A winc or rinc presented in the same cycle as flush is discarded and sets no error flag.
- overflow is set by winc && wfull && !flush. underflow is set by rinc && rempty && !flush.
- err_clr clears both sticky flags. If a set condition and err_clr occur in the same cycle, the set wins.

## Timing
- Reset values (immediately on rst_n low, no clock required):
  - level=0, waddr=raddr=0
  - rempty=1, wfull=0
  - overflow=underflow=0
  - rdata=0 in "FALSE" mode
  - arempty=1 for any threshold
  - awfull = (afull_thresh==0)
- Deassertion of reset is synchronised externally. The first edge after release may accept a write.
- Write-to-visible latency is one edge. A write accepted at edge N gives level+1, rempty=0 and (in "TRUE" mode) rdata=wdata, all after edge N.
- "FALSE" mode: rinc accepted at edge N presents the popped word on rdata after edge N.
- Flags, level and sticky errors all change only after a clock edge or on reset.
- Reset asserted mid-operation aborts in-flight accesses. All state returns to reset values.

## Test plan
- Full/overflow: DSIZE=8, ASIZE=4. Write 0x00..0x0F on 16 consecutive edges, then assert winc once more with 0xFF. Required: wfull=1 and level=16 after the 16th edge; overflow=1 after the 17th edge; 16 reads return 0x00..0x0F in order, then rempty=1.
- Latency per mode: write 0xA5 at edge N into an empty FIFO. Required in "TRUE" mode: rdata=0xA5 and rempty=0 after edge N. Required in "FALSE" mode: rdata=0xA5 only after the rinc edge, with rdata=0 before it.
- Simultaneous read/write:
  - at level 8, winc and rinc for 20 cycles: level stays 8 and data order is preserved;
  - at level 16: level goes to 15 and overflow=1;
  - at level 0: level goes to 1 and underflow=1.
- Thresholds: afull_thresh=12, aempty_thresh=3, writes only from empty. Required: arempty=1 through level 3 and 0 from level 4; awfull=0 through level 11 and 1 at level 12.
- Flush and reset: at level 9, assert flush together with winc. Required: level=0 after the edge, write discarded, no overflow. Then write 0x3C; the first read returns 0x3C. Drop rst_n between edges at level 5: level=0 and rempty=1 immediately.
- Sticky clear: set underflow, then assert err_clr together with rinc on an empty FIFO. Required: underflow remains 1. err_clr alone on the next cycle: underflow=0.
